// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg -- shared types and constants for the binary/BCD conversion blocks.
//
// Contents:
//   bcd_digit_t      one packed BCD digit (4 bits)
//   BCD_ADD3_THRESH  digit value at or above which double dabble adds 3
//   BCD_ADD3_VAL     correction added to such a digit before the shift
//   BCD_MAX2         largest value representable in two BCD digits
//   bcd_min_digits() decimal digits needed to hold 2^mag_w - 1
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ADD3_THRESH = 4'd5;
  localparam bcd_digit_t BCD_ADD3_VAL    = 4'd3;
  localparam int         BCD_MAX2        = 99;

  // Smallest DIGITS such that 10^DIGITS > 2^mag_w - 1. Evaluated at
  // elaboration time to reject under-sized converters.
  function automatic int bcd_min_digits(input int mag_w);
    longint unsigned one;
    longint unsigned max_val;
    int              d;
    one     = 1;
    max_val = (one << mag_w) - one;
    d       = 1;
    while (max_val >= 10) begin
      max_val = max_val / 10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3 -- combinational double-dabble correction for one BCD digit.
// A digit of 5..9 gets +3 so that the following left shift carries into the
// next digit exactly when the doubled value reaches 10. Only digits 0..9 ever
// reach this block, so the 4-bit sum cannot overflow.
//
// Ports:
//   din   in   current digit of the BCD work register
//   dout  out  corrected digit, ready to be shifted
// ---------------------------------------------------------------------------
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  assign dout = (din >= BCD_ADD3_THRESH) ? din + BCD_ADD3_VAL : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq -- sequential sign+magnitude binary to packed BCD converter.
// Shift-add-3 (double dabble), one magnitude bit per clock. A conversion is
// accepted in IDLE, runs MAG_W SHIFT cycles and is presented in DONE until
// the consumer takes it. The sign is carried through untouched, so negative
// zero survives.
//
// Build option: define BIN2BCD_CLAMP99_EN to clamp results above 99 to 0x99
// and raise out_ovf. Without it out_ovf is constant 0 and the full DIGITS
// wide result is produced. Handshake and latency are the same in both builds.
//
// Parameters:
//   MAG_W   magnitude width in bits (sign separate)
//   DIGITS  BCD output digits; must satisfy 10^DIGITS > 2^MAG_W - 1
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_sign/in_mag valid
//   in_ready   out  converter idle, can accept input
//   in_sign    in   sign, 1 = negative
//   in_mag     in   unsigned magnitude
//   out_valid  out  result valid, held until taken
//   out_ready  in   consumer accepts result
//   out_sign   out  registered sign
//   out_bcd    out  packed BCD, digit 0 in [3:0]
//   out_ovf    out  clamp flag
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int MAG_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [MAG_W-1:0]      in_mag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(MAG_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAG_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  if (DIGITS < bcd_min_digits(MAG_W)) begin : g_size_check
    $fatal(1, "bin2bcd_seq: DIGITS=%0d too small for MAG_W=%0d", DIGITS, MAG_W);
  end

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [MAG_W-1:0] shift_reg;
  logic [BCD_W-1:0] bcd_work;
  logic             sign_work;

  logic [BCD_W-1:0] bcd_corr;
  logic [BCD_W-1:0] bcd_nxt;
  logic [MAG_W-1:0] sreg_nxt;
  logic [BCD_W-1:0] res_bcd;
  logic             res_ovf;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3 u_add3 (
      .din  (bcd_work[4*i +: 4]),
      .dout (bcd_corr[4*i +: 4])
    );
  end

  // Correct every digit, then shift {bcd, bin} left by one. The top bit of
  // the corrected BCD is always 0 for in-range inputs, so dropping it is safe.
  assign {bcd_nxt, sreg_nxt} = {bcd_corr[BCD_W-2:0], shift_reg, 1'b0};

`ifdef BIN2BCD_CLAMP99_EN
  localparam logic [BCD_W-1:0] CLAMP_BCD = BCD_W'(8'h99);

  // Range flag is taken from the original magnitude at accept time, since
  // the shift register no longer holds it by the end of the conversion.
  logic mag_gt99;

  assign res_bcd = mag_gt99 ? CLAMP_BCD : bcd_nxt;
  assign res_ovf = mag_gt99;
`else
  assign res_bcd = bcd_nxt;
  assign res_ovf = 1'b0;
`endif

  // NOTE: every register here uses <= so all state updates see the values
  // from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shift_reg <= '0;
      bcd_work  <= '0;
      sign_work <= 1'b0;
      out_sign  <= 1'b0;
      out_bcd   <= '0;
      out_ovf   <= 1'b0;
`ifdef BIN2BCD_CLAMP99_EN
      mag_gt99  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= in_mag;
            bcd_work  <= '0;
            sign_work <= in_sign;
            cnt       <= '0;
`ifdef BIN2BCD_CLAMP99_EN
            mag_gt99  <= 32'(in_mag) > BCD_MAX2;
`endif
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= sreg_nxt;
          bcd_work  <= bcd_nxt;
          cnt       <= cnt + CNT_W'(1);
          // Last iteration: publish the freshly shifted value directly so the
          // result is visible MAG_W cycles after the accepting edge.
          if (cnt == CNT_LAST) begin
            out_bcd  <= res_bcd;
            out_sign <= sign_work;
            out_ovf  <= res_ovf;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule
